// File: rtl/iter_muldiv.sv
// iter_muldiv: iterative multiply/divide unit. Shift-add multiply (LSB first), restoring divide (MSB first), one bit per cycle.
// Optional signed ops on op[1] are built only when the macro ITER_MULDIV_SIGNED_EN is defined.
module iter_muldiv #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             kill,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q;
  logic             busy_q, done_q, dbz_q;
  logic [WIDTH-1:0] res_lo_q, res_hi_q;
  logic [WIDTH-1:0] hi_q, lo_q, mc_q;
  logic             div_q, neg_lo_q, neg_hi_q;
  logic [CW-1:0]    cnt_q;

  logic             is_div, div_zero, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign is_div   = op[0];
  assign div_zero = is_div && (b == '0);

`ifdef ITER_MULDIV_SIGNED_EN
  assign a_neg = op[1] & a[WIDTH-1];
  assign b_neg = op[1] & b[WIDTH-1];
`else
  logic unused_op_hi;
  assign unused_op_hi = op[1];
  assign a_neg = 1'b0;
  assign b_neg = 1'b0;
`endif

  // The core always works on magnitudes; signs are reapplied when the result is captured.
  assign a_mag = a_neg ? (WIDTH'(0) - a) : a;
  assign b_mag = b_neg ? (WIDTH'(0) - b) : b;

  logic [WIDTH:0]   mul_sum, div_shift;
  logic [WIDTH-1:0] div_diff, hi_step, lo_step;
  logic             div_ge;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mc_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, mc_q});
    div_diff  = div_shift[WIDTH-1:0] - mc_q;
    hi_step   = mul_sum[WIDTH:1];
    lo_step   = {mul_sum[0], lo_q[WIDTH-1:1]};
    if (div_q) begin
      hi_step = div_ge ? div_diff : div_shift[WIDTH-1:0];
      lo_step = {lo_q[WIDTH-2:0], div_ge};
    end
  end

  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   fin_lo, fin_hi;

  always_comb begin
    prod     = {hi_step, lo_step};
    prod_fix = neg_lo_q ? ((2*WIDTH)'(0) - prod) : prod;
    {fin_hi, fin_lo} = prod_fix;
    if (div_q) begin
      fin_lo = neg_lo_q ? (WIDTH'(0) - lo_step) : lo_step;
      fin_hi = neg_hi_q ? (WIDTH'(0) - hi_step) : hi_step;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      mc_q     <= '0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      cnt_q    <= '0;
    end else if (kill) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
          if (start) begin
            if (div_zero) begin
              // Divide by zero bypasses the iteration and completes immediately.
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              res_lo_q <= '1;
              res_hi_q <= a;
              dbz_q    <= 1'b1;
            end else begin
              state_q  <= S_RUN;
              busy_q   <= 1'b1;
              cnt_q    <= '0;
              hi_q     <= '0;
              lo_q     <= is_div ? a_mag : b_mag;
              mc_q     <= is_div ? b_mag : a_mag;
              div_q    <= is_div;
              neg_lo_q <= a_neg ^ b_neg;
              neg_hi_q <= is_div ? a_neg : (a_neg ^ b_neg);
            end
          end
        end
        S_RUN: begin
          hi_q  <= hi_step;
          lo_q  <= lo_step;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q  <= S_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            res_lo_q <= fin_lo;
            res_hi_q <= fin_hi;
            dbz_q    <= 1'b0;
            cnt_q    <= '0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result_lo   = res_lo_q;
  assign result_hi   = res_hi_q;
  assign div_by_zero = dbz_q;

endmodule
